// File: rtl/fir_param_pipe.sv
// Transposed-form parameterised FIR with a writable coefficient file,
// a 1-cycle registered output and a selectable saturate/wrap output stage.
module fir_param_pipe #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        x,
    input  logic                     x_valid,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     sat_en,
    input  logic                     flush,
    output logic [OUT_W-1:0]         y,
    output logic                     y_valid,
    output logic                     ovf
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;

    logic [COEF_W-1:0] c_r     [TAPS];
    logic [ACC_W-1:0]  r_r     [TAPS-1];
    logic [ACC_W-1:0]  r_nxt_s [TAPS-1];
    logic [ACC_W-1:0]  s_s;
    logic              ovf_s;
    logic              addr_ok_s;
    logic [OUT_W-1:0]  y_map_s;
    logic [OUT_W-1:0]  y_r;
    logic              y_valid_r;
    logic              ovf_r;

    function automatic logic [ACC_W-1:0] tap_mul(input logic [DATA_W-1:0] a,
                                                 input logic [COEF_W-1:0] b);
        return ACC_W'(a) * ACC_W'(b);
    endfunction

    // Next partial sums and the output sum for the current sample.
    always_comb begin
        for (int k = 0; k < TAPS - 2; k++) begin
            r_nxt_s[k] = tap_mul(x, c_r[k+1]) + r_r[k+1];
        end
        r_nxt_s[TAPS-2] = tap_mul(x, c_r[TAPS-1]);
        s_s = tap_mul(x, c_r[0]) + r_r[0];
    end

    // Output range check and saturate/wrap mapping.
    always_comb begin
        ovf_s   = ((s_s >> OUT_W) != '0);
        y_map_s = s_s[OUT_W-1:0];
        if (ovf_s && sat_en) begin
            y_map_s = '1;
        end else begin
            y_map_s = s_s[OUT_W-1:0];
        end
    end

    // Out-of-range indices are dropped; only reachable when TAPS is not a power of two.
    always_comb begin
        if (32'(coef_addr) < 32'(TAPS)) begin
            addr_ok_s = 1'b1;
        end else begin
            addr_ok_s = 1'b0;
        end
    end

    // Coefficient register file; flush leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                c_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_we && addr_ok_s && (coef_addr == ADDR_W'(k))) begin
                    c_r[k] <= coef_data;
                end
            end
        end
    end

    // Delay line, output register and sticky overflow; flush beats a sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                r_r[k] <= '0;
            end
            y_r       <= '0;
            y_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                r_r[k] <= '0;
            end
            y_r       <= '0;
            y_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (x_valid) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                r_r[k] <= r_nxt_s[k];
            end
            y_r       <= y_map_s;
            y_valid_r <= 1'b1;
            ovf_r     <= ovf_r | ovf_s;
        end else begin
            y_valid_r <= 1'b0;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_fir_param_pipe.sv
// Directed bench for fir_param_pipe: a 16-bit-output and a 12-bit-output
// instance share all inputs so saturation and wrap can be checked side by side.
module tb_fir_param_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic        x_valid;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        sat_en;
    logic        flush;
    logic [15:0] y;
    logic        y_valid;
    logic        ovf;
    logic [11:0] y12;
    logic        y_valid12;
    logic        ovf12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_param_pipe #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(16)) dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .sat_en(sat_en), .flush(flush),
        .y(y), .y_valid(y_valid), .ovf(ovf)
    );

    fir_param_pipe #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(12)) dut12 (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .sat_en(sat_en), .flush(flush),
        .y(y12), .y_valid(y_valid12), .ovf(ovf12)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one falling edge later.
    task automatic push(input logic [7:0] xv, input logic v);
        x       = xv;
        x_valid = v;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic wcoef(input logic [1:0] a, input logic [7:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic load_coefs();
        wcoef(2'd0, 8'd8);
        wcoef(2'd1, 8'd7);
        wcoef(2'd2, 8'd6);
        wcoef(2'd3, 8'd5);
    endtask

    int imp_y  [5] = '{8, 7, 6, 5, 0};
    int step_y [6] = '{2040, 3825, 5355, 6630, 6630, 6630};
    int sat_y  [6] = '{2040, 3825, 4095, 4095, 4095, 4095};
    int wrap_y [6] = '{2040, 3825, 1259, 2534, 2534, 2534};
    // Gapped impulse: {x, x_valid, expected y, expected y_valid}
    int gap_v  [8][4] = '{'{1,1,8,1}, '{0,0,8,0}, '{0,1,7,1}, '{0,0,7,0},
                          '{0,1,6,1}, '{0,1,5,1}, '{0,0,5,0}, '{0,1,0,1}};

    initial begin
        reset = 1'b0; x = 8'd0; x_valid = 1'b0; coef_we = 1'b0;
        coef_addr = 2'd0; coef_data = 8'd0; sat_en = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_y", int'(y), 0);
        check_val("rst_yv", int'(y_valid), 0);
        check_val("rst_ovf", int'(ovf), 0);

        load_coefs();
        for (int i = 0; i < 5; i++) begin
            push((i == 0) ? 8'd1 : 8'd0, 1'b1);
            check_val($sformatf("imp_y%0d", i), int'(y), imp_y[i]);
            check_val($sformatf("imp_yv%0d", i), int'(y_valid), 1);
        end
        @(negedge clk);
        check_val("imp_yv_idle", int'(y_valid), 0);

        sat_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(8'd255, 1'b1);
            check_val($sformatf("step_y%0d", i), int'(y), step_y[i]);
            check_val($sformatf("sat_y%0d", i), int'(y12), sat_y[i]);
        end
        check_val("step_ovf16", int'(ovf), 0);
        check_val("sat_ovf12", int'(ovf12), 1);

        do_flush();
        check_val("flush_ovf12", int'(ovf12), 0);
        sat_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(8'd255, 1'b1);
            check_val($sformatf("wrap_y%0d", i), int'(y12), wrap_y[i]);
        end
        check_val("wrap_ovf12", int'(ovf12), 1);
        check_val("wrap_ovf16", int'(ovf), 0);

        do_flush();
        for (int i = 0; i < 8; i++) begin
            push(8'(gap_v[i][0]), gap_v[i][1] != 0);
            check_val($sformatf("gap_y%0d", i), int'(y), gap_v[i][2]);
            check_val($sformatf("gap_yv%0d", i), int'(y_valid), gap_v[i][3]);
        end

        // Sample and c[0] write on the same edge: sample sees the old 8.
        x = 8'd1; x_valid = 1'b1;
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd3;
        @(negedge clk);
        x_valid = 1'b0; coef_we = 1'b0;
        check_val("cw_old", int'(y), 8);
        for (int i = 0; i < 3; i++) push(8'd0, 1'b1);
        check_val("cw_tail", int'(y), 5);
        push(8'd1, 1'b1);
        check_val("cw_new", int'(y), 3);
        wcoef(2'd0, 8'd8);
        do_flush();

        for (int i = 0; i < 3; i++) push(8'd255, 1'b1);
        check_val("fl_pre", int'(y), 5355);
        check_val("fl_pre_ovf12", int'(ovf12), 1);
        x = 8'd255; x_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        x_valid = 1'b0; flush = 1'b0;
        check_val("fl_y", int'(y), 0);
        check_val("fl_yv", int'(y_valid), 0);
        check_val("fl_ovf", int'(ovf), 0);
        check_val("fl_ovf12", int'(ovf12), 0);
        push(8'd255, 1'b1);
        check_val("fl_restart", int'(y), 2040);
        push(8'd255, 1'b1);
        check_val("fl_restart2", int'(y), 3825);

        push(8'd255, 1'b1);
        reset = 1'b0;
        #2;
        check_val("ar_y", int'(y), 0);
        check_val("ar_yv", int'(y_valid), 0);
        check_val("ar_ovf12", int'(ovf12), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push(8'd255, 1'b1);
        check_val("ar_nocoef_y", int'(y), 0);
        check_val("ar_nocoef_yv", int'(y_valid), 1);
        load_coefs();
        push(8'd255, 1'b1);
        check_val("ar_restart", int'(y), 2040);
        push(8'd255, 1'b1);
        check_val("ar_restart2", int'(y), 3825);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_param_pipe.md
FIR_PARAM_PIPE -- requirements
Module: fir_param_pipe

Interface
REQ-001 Parameter DATA_W, default 8, unsigned input sample width.
REQ-002 Parameter COEF_W, default 8, unsigned coefficient width.
REQ-003 Parameter TAPS, default 4, tap count; legal range 2..16.
REQ-004 Parameter OUT_W, default 16, output width; legal range 1..ACC_W, where ACC_W = DATA_W+COEF_W+clog2(TAPS).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 x  input  DATA_W  input sample.
REQ-008 x_valid  input  1  x is a new sample this cycle.
REQ-009 coef_we  input  1  coefficient write strobe.
REQ-010 coef_addr  input  clog2(TAPS)  coefficient index k, 0..TAPS-1.
REQ-011 coef_data  input  COEF_W  coefficient write value.
REQ-012 sat_en  input  1  mode select: 1 = saturate output, 0 = wrap output.
REQ-013 flush  input  1  synchronous clear of the delay line.
REQ-014 y  output  OUT_W  filtered output, registered.
REQ-015 y_valid  output  1  y holds a new result this cycle.
REQ-016 ovf  output  1  sticky flag: a result exceeded OUT_W.

Function
REQ-017 The block SHALL implement transposed-form y[n] = sum over k of c[k]*x[n-k], with unsigned arithmetic at full ACC_W precision internally.
REQ-018 The block SHALL hold TAPS-1 partial-sum registers r[0..TAPS-2], each ACC_W bits wide, and a coefficient register file c[0..TAPS-1].
REQ-019 On a cycle with x_valid=1, the block SHALL update r[k] <= x*c[k+1] + r[k+1] for k < TAPS-2, and r[TAPS-2] <= x*c[TAPS-1].
REQ-020 On a cycle with x_valid=1, the block SHALL register s = x*c[0] + r[0] into y, giving 1-cycle latency; y_valid SHALL be x_valid delayed by one cycle.
REQ-021 When x_valid=0, r SHALL hold its value and y SHALL hold its last value; y_valid SHALL be 0 on the following cycle.
REQ-022 Output mapping: if s < 2^OUT_W, y SHALL be s; otherwise y SHALL be 2^OUT_W-1 when sat_en=1, or s mod 2^OUT_W when sat_en=0.
REQ-023 ovf SHALL set on any valid result with s >= 2^OUT_W, regardless of sat_en, and SHALL clear only on reset or flush.
REQ-024 When coef_we=1, c[coef_addr] SHALL take coef_data at the clock edge.
REQ-025 A sample accepted in the same cycle as a coefficient write SHALL use the old coefficient value; the new value applies from the next sample onward.
REQ-026 If coef_addr >= TAPS, the write SHALL be ignored.
REQ-027 When flush=1, the block SHALL zero r, y, y_valid and ovf at the next edge; coefficients SHALL be retained.
REQ-028 flush SHALL take priority over x_valid in the same cycle: the sample is discarded and no y_valid is produced.
REQ-029 sat_en SHALL be sampled in the cycle the sample is accepted.

Reset
REQ-030 While reset=0, the block SHALL asynchronously clear r, c, y, y_valid and ovf to 0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight partial sums; the first valid y after release SHALL reflect only post-reset samples.
REQ-032 No sample SHALL be accepted on the first clock edge after reset is released if that release is asynchronous to clk; the bench SHALL deassert reset synchronously with clk.

Verification
REQ-033 Impulse test: load c = {8,7,6,5}, then drive x = 1,0,0,0,0 with x_valid=1 -> y = 8,7,6,5,0 on consecutive cycles, each one cycle after its input.
REQ-034 Step test: same coefficients, x = 255 held for 6 samples with OUT_W=16 -> y = 2040, 3825, 5355, 6630, 6630, 6630; ovf=0.
REQ-035 Saturation/wrap test: OUT_W=12, step input of 255 -> steady-state y = 4095 with sat_en=1, y = 2534 with sat_en=0; ovf=1 in both cases.
REQ-036 Gapped-valid test: insert x_valid=0 bubbles into the impulse test -> identical y sequence, with y_valid low during the bubbles and y held.
REQ-037 Coefficient write in the same cycle as x=1 changes c[0] from 8 to 3 -> that sample yields y=8, and the next impulse yields y=3.
REQ-038 Flush/reset test: apply flush, and separately a reset pulse, mid-step -> y=0, ovf=0, next outputs restart from 2040; coefficients survive flush, and after reset y stays 0 until coefficients are reloaded.
